// File: rtl/vc_route_unit.sv
// Per-VC wormhole route computation for one mesh router input port.
// Registers the output port on a head flit and holds it until the tail flit.
module vc_route_unit #(
  parameter int MESH_SIZE_X      = 5,
  parameter int MESH_SIZE_Y      = 5,
  parameter int X_CURRENT        = MESH_SIZE_X / 2,
  parameter int Y_CURRENT        = MESH_SIZE_Y / 2,
  parameter int VC_NUM           = 2,
  parameter int ROUTING_MODE     = 0,
  parameter int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X),
  parameter int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flit_valid_i,
  input  logic [((VC_NUM > 1) ? $clog2(VC_NUM) : 1)-1:0] flit_vc_i,
  input  logic [1:0]                    flit_type_i,
  input  logic [DEST_ADDR_SIZE_X-1:0]   x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0]   y_dest_i,
  output logic [VC_NUM-1:0]             route_valid_o,
  output logic [VC_NUM-1:0][2:0]        out_port_o,
  output logic                          seq_error_o,
  output logic                          dest_error_o
);

  localparam int DXW = DEST_ADDR_SIZE_X + 1;
  localparam int DYW = DEST_ADDR_SIZE_Y + 1;
  localparam logic [DXW-1:0] MX = DXW'(MESH_SIZE_X);
  localparam logic [DYW-1:0] MY = DYW'(MESH_SIZE_Y);
  localparam logic [DEST_ADDR_SIZE_X-1:0] XC = DEST_ADDR_SIZE_X'(X_CURRENT);
  localparam logic [DEST_ADDR_SIZE_Y-1:0] YC = DEST_ADDR_SIZE_Y'(Y_CURRENT);

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_SOUTH = 3'd2;
  localparam logic [2:0] P_WEST  = 3'd3;
  localparam logic [2:0] P_EAST  = 3'd4;

  typedef enum logic {IDLE = 1'b0, ROUTED = 1'b1} st_t;

  st_t                    r_st [VC_NUM];
  st_t                    w_st [VC_NUM];
  logic [VC_NUM-1:0]      r_ht;
  logic [VC_NUM-1:0]      w_ht;
  logic [VC_NUM-1:0][2:0] r_port;
  logic [VC_NUM-1:0][2:0] w_port;
  logic                   r_seq;
  logic                   w_seq;
  logic                   r_dest;
  logic                   w_dest;

  logic       w_head;
  logic       w_in_range;
  logic       w_vc_ok;
  logic       w_xe;
  logic       w_xw;
  logic       w_ys;
  logic       w_yn;
  logic [2:0] w_route;

  assign w_head     = (flit_type_i == 2'b00) || (flit_type_i == 2'b11);
  assign w_in_range = ({1'b0, x_dest_i} < MX) && ({1'b0, y_dest_i} < MY);
  assign w_vc_ok    = int'(flit_vc_i) < VC_NUM;

  assign w_xe = x_dest_i > XC;
  assign w_xw = x_dest_i < XC;
  assign w_ys = y_dest_i > YC;
  assign w_yn = y_dest_i < YC;

  always_comb begin
    w_route = P_LOCAL;
    if (ROUTING_MODE == 0) begin
      priority case (1'b1)
        w_xe:    w_route = P_EAST;
        w_xw:    w_route = P_WEST;
        w_ys:    w_route = P_SOUTH;
        w_yn:    w_route = P_NORTH;
        default: w_route = P_LOCAL;
      endcase
    end else begin
      priority case (1'b1)
        w_ys:    w_route = P_SOUTH;
        w_yn:    w_route = P_NORTH;
        w_xe:    w_route = P_EAST;
        w_xw:    w_route = P_WEST;
        default: w_route = P_LOCAL;
      endcase
    end
  end

  // A VC still showing a HEADTAIL pulse already carries a finished packet,
  // so it accepts a new head just like an idle VC.
  always_comb begin
    w_seq  = r_seq;
    w_dest = r_dest;
    w_port = r_port;
    w_ht   = '0;
    for (int v = 0; v < VC_NUM; v++)
      w_st[v] = r_ht[v] ? IDLE : r_st[v];
    if (flit_valid_i) begin
      if (!w_vc_ok) w_seq = 1'b1;
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_vc_ok && v == int'(flit_vc_i)) begin
          if (r_st[v] == IDLE || r_ht[v]) begin
            if (!w_head) begin
              w_seq = 1'b1;
            end else if (!w_in_range) begin
              w_dest = 1'b1;
            end else begin
              w_st[v]   = ROUTED;
              w_port[v] = w_route;
              w_ht[v]   = (flit_type_i == 2'b11);
            end
          end else if (w_head) begin
            w_seq = 1'b1;
          end else if (flit_type_i == 2'b10) begin
            w_st[v] = IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) r_st[v] <= IDLE;
      r_ht   <= '0;
      r_port <= '0;
      r_seq  <= 1'b0;
      r_dest <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) r_st[v] <= w_st[v];
      r_ht   <= w_ht;
      r_port <= w_port;
      r_seq  <= w_seq;
      r_dest <= w_dest;
    end
  end

  always_comb begin
    route_valid_o = '0;
    for (int v = 0; v < VC_NUM; v++)
      route_valid_o[v] = (r_st[v] == ROUTED);
  end

  assign out_port_o   = r_port;
  assign seq_error_o  = r_seq;
  assign dest_error_o = r_dest;

endmodule

// File: tb/tb_vc_route_unit.sv
// Bench for vc_route_unit: XY and YX instances on a 5x5 mesh at (2,2),
// directed scenarios plus random flits checked against a packet-level model.
module tb_vc_route_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fv  = 1'b0;
  logic       fvc = 1'b0;
  logic [1:0] ftype = 2'b00;
  logic [2:0] xd = 3'd0;
  logic [2:0] yd = 3'd0;

  logic [1:0]      rv_xy, rv_yx;
  logic [1:0][2:0] pt_xy, pt_yx;
  logic            se_xy, se_yx, de_xy, de_yx;

  int errors = 0;
  int checks = 0;

  // model state
  bit       m_open  [2];
  bit       m_pulse [2];
  int       m_pxy   [2];
  int       m_pyx   [2];
  bit       m_seq;
  bit       m_dest;

  always #5 clk = ~clk;

  vc_route_unit #(.ROUTING_MODE(0)) u_xy (
    .clk(clk), .rst(rst), .flit_valid_i(fv), .flit_vc_i(fvc),
    .flit_type_i(ftype), .x_dest_i(xd), .y_dest_i(yd),
    .route_valid_o(rv_xy), .out_port_o(pt_xy),
    .seq_error_o(se_xy), .dest_error_o(de_xy)
  );

  vc_route_unit #(.ROUTING_MODE(1)) u_yx (
    .clk(clk), .rst(rst), .flit_valid_i(fv), .flit_vc_i(fvc),
    .flit_type_i(ftype), .x_dest_i(xd), .y_dest_i(yd),
    .route_valid_o(rv_yx), .out_port_o(pt_yx),
    .seq_error_o(se_yx), .dest_error_o(de_yx)
  );

  // 0 LOCAL, 1 NORTH, 2 SOUTH, 3 WEST, 4 EAST
  function automatic int ref_port(input int mode, input int x, input int y);
    int dx = x - 2;
    int dy = y - 2;
    int px = (dx > 0) ? 4 : (dx < 0) ? 3 : 0;
    int py = (dy > 0) ? 2 : (dy < 0) ? 1 : 0;
    if (mode == 0) return (px != 0) ? px : py;
    return (py != 0) ? py : px;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_open[v] = 0; m_pulse[v] = 0; m_pxy[v] = 0; m_pyx[v] = 0;
    end
    m_seq = 0; m_dest = 0;
  endtask

  task automatic model_edge(input bit v_i, input int vc, input int t,
                            input int x, input int y);
    bit free;
    bit head;
    free = !m_open[vc];
    for (int v = 0; v < 2; v++) m_pulse[v] = 0;
    if (!v_i) return;
    head = (t == 0) || (t == 3);
    if (free) begin
      if (!head) m_seq = 1;
      else if (x >= 5 || y >= 5) m_dest = 1;
      else begin
        m_pxy[vc] = ref_port(0, x, y);
        m_pyx[vc] = ref_port(1, x, y);
        if (t == 3) m_pulse[vc] = 1;
        else m_open[vc] = 1;
      end
    end else if (head) m_seq = 1;
    else if (t == 2) m_open[vc] = 0;
  endtask

  task automatic check_all(input string tag);
    for (int v = 0; v < 2; v++) begin
      int ev = int'(m_open[v] | m_pulse[v]);
      chk($sformatf("%s rv_xy[%0d]", tag, v), int'(rv_xy[v]), ev);
      chk($sformatf("%s rv_yx[%0d]", tag, v), int'(rv_yx[v]), ev);
      chk($sformatf("%s port_xy[%0d]", tag, v), int'(pt_xy[v]), m_pxy[v]);
      chk($sformatf("%s port_yx[%0d]", tag, v), int'(pt_yx[v]), m_pyx[v]);
    end
    chk({tag, " seq_xy"}, int'(se_xy), int'(m_seq));
    chk({tag, " seq_yx"}, int'(se_yx), int'(m_seq));
    chk({tag, " dest_xy"}, int'(de_xy), int'(m_dest));
    chk({tag, " dest_yx"}, int'(de_yx), int'(m_dest));
  endtask

  task automatic step(input bit v_i, input int vc, input int t,
                      input int x, input int y);
    fv = v_i; fvc = 1'(vc); ftype = 2'(t); xd = 3'(x); yd = 3'(y);
    @(posedge clk);
    model_edge(v_i, vc, t, x, y);
    #1;
    fv = 1'b0;
    check_all("step");
  endtask

  // rst rises between edges and must clear outputs before the next edge
  task automatic async_reset();
    fv = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam int HEAD = 0, BODY = 1, TAIL = 2, HT = 3;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // reset mid-packet
    step(1, 0, HEAD, 4, 2);
    chk("head east", int'(pt_xy[0]), 4);
    step(1, 0, BODY, 0, 0);
    async_reset();
    chk("rst rv", int'(rv_xy), 0);
    chk("rst port", int'(pt_xy[0]), 0);
    step(1, 0, BODY, 0, 0);
    chk("body after rst seq", int'(se_xy), 1);
    async_reset();

    // full sweep with HEADTAIL pulses
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        step(1, 0, HT, x, y);
        chk("ht pulse", int'(rv_xy[0]), 1);
        if (x == 4 && y == 0) begin
          chk("xy (4,0)", int'(pt_xy[0]), 4);
          chk("yx (4,0)", int'(pt_yx[0]), 1);
        end
        if (x == 2 && y == 0) chk("xy (2,0)", int'(pt_xy[0]), 1);
        if (x == 2 && y == 4) chk("xy (2,4)", int'(pt_xy[0]), 2);
        if (x == 0 && y == 3) chk("xy (0,3)", int'(pt_xy[0]), 3);
        if (x == 2 && y == 2) chk("xy (2,2)", int'(pt_xy[0]), 0);
        if (x == 0 && y == 4) chk("yx (0,4)", int'(pt_yx[0]), 2);
        if (x == 3 && y == 2) chk("yx (3,2)", int'(pt_yx[0]), 4);
        step(0, 0, 0, 0, 0);
        chk("ht pulse end", int'(rv_xy[0]), 0);
      end

    // interleaved VCs
    step(1, 0, HEAD, 0, 2);
    step(1, 1, HEAD, 4, 4);
    chk("il vc0 west", int'(pt_xy[0]), 3);
    chk("il vc1 east", int'(pt_xy[1]), 4);
    step(1, 0, BODY, 0, 0);
    step(1, 1, TAIL, 0, 0);
    chk("il vc1 fall", int'(rv_xy[1]), 0);
    chk("il vc0 hold", int'(rv_xy[0]), 1);
    step(1, 0, TAIL, 0, 0);
    chk("il vc0 fall", int'(rv_xy[0]), 0);
    chk("il vc0 port kept", int'(pt_xy[0]), 3);

    // back-to-back packets on VC1
    step(1, 1, HEAD, 4, 4);
    step(1, 1, TAIL, 0, 0);
    step(1, 1, HEAD, 2, 0);
    chk("b2b rv", int'(rv_xy[1]), 1);
    chk("b2b north", int'(pt_xy[1]), 1);
    step(1, 1, TAIL, 0, 0);
    chk("seq clean", int'(se_xy), 0);

    // errors on VC0
    async_reset();
    step(1, 0, HEAD, 5, 1);
    chk("dest err", int'(de_xy), 1);
    chk("dest idle", int'(rv_xy[0]), 0);
    step(1, 0, HEAD, 1, 1);
    step(1, 0, HEAD, 3, 3);
    chk("seq err", int'(se_xy), 1);
    chk("route kept", int'(pt_xy[0]), 3);
    chk("route kept rv", int'(rv_xy[0]), 1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0) async_reset();
      step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
